// File: rtl/muldiv_seq_unit.sv
// Multi-cycle 8-bit unsigned multiply/divide unit writing its two result bytes back through a register-file write port.
// Optional feature macro: MULDIV_EARLY_OUT_EN (skips CALC for zero multiplies and divide-by-zero).
module muldiv_seq_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] dest,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic              dbz,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wd,
    output logic              we
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, WB_LO, WB_HI} state_t;

    state_t              state, next_state;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                op_r, op_next;
    logic [ADDR_W-1:0]   dest_r, dest_next;
    logic [DATA_W-1:0]   m_r, m_next;
    logic [DATA_W-1:0]   hi, hi_next;
    logic [DATA_W-1:0]   lo, lo_next;
    logic                dbz_next;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     shifted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // hi:lo is the product for MUL and remainder:quotient for DIV, so write-back is identical for both ops.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        op_next    = op_r;
        dest_next  = dest_r;
        m_next     = m_r;
        hi_next    = hi;
        lo_next    = lo;
        dbz_next   = dbz;
        sum        = '0;
        shifted    = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = CALC;
                    cnt_next   = '0;
                    op_next    = op;
                    dest_next  = dest;
                    dbz_next   = op && (op_b == '0);
                    hi_next    = '0;
                    if (op) begin
                        m_next  = op_b;
                        lo_next = op_a;
                    end else begin
                        m_next  = op_a;
                        lo_next = op_b;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    if (!op && ((op_a == '0) || (op_b == '0))) begin
                        next_state = WB_LO;
                        lo_next    = '0;
                    end else if (op && (op_b == '0)) begin
                        next_state = WB_LO;
                        hi_next    = op_a;
                        lo_next    = '1;
                    end
`endif
                end
            end
            CALC: begin
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    next_state = WB_LO;
                end
                if (!op_r) begin
                    sum                = {1'b0, hi} + {1'b0, (lo[0] ? m_r : '0)};
                    {hi_next, lo_next} = {sum, lo[DATA_W-1:1]};
                end else begin
                    // Restoring step: a divisor of zero always "fits", giving Q=all ones and R=dividend.
                    shifted = {hi, lo[DATA_W-1]};
                    if (shifted >= {1'b0, m_r}) begin
                        hi_next = shifted[DATA_W-1:0] - m_r;
                        lo_next = {lo[DATA_W-2:0], 1'b1};
                    end else begin
                        hi_next = shifted[DATA_W-1:0];
                        lo_next = {lo[DATA_W-2:0], 1'b0};
                    end
                end
            end
            WB_LO:   next_state = WB_HI;
            WB_HI:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in the matching state's cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_r   <= 1'b0;
            dest_r <= '0;
            m_r    <= '0;
            hi     <= '0;
            lo     <= '0;
            dbz    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            we     <= 1'b0;
            wa     <= '0;
            wd     <= '0;
        end else begin
            cnt    <= cnt_next;
            op_r   <= op_next;
            dest_r <= dest_next;
            m_r    <= m_next;
            hi     <= hi_next;
            lo     <= lo_next;
            dbz    <= dbz_next;
            busy   <= (next_state != IDLE);
            done   <= (next_state == WB_HI);
            we     <= (next_state == WB_LO) || (next_state == WB_HI);
            if (next_state == WB_LO) begin
                wa <= dest_next;
                wd <= lo_next;
            end else if (next_state == WB_HI) begin
                wa <= dest_next + ADDR_W'(1);
                wd <= hi_next;
            end else begin
                wa <= '0;
                wd <= '0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Scoreboard bench for muldiv_seq_unit: directed operations queue expected writes, a monitor checks them.
// Honours MULDIV_EARLY_OUT_EN for the expected latency of zero-multiply and divide-by-zero cases.
module tb_muldiv_seq_unit;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              op = 1'b0;
    logic [ADDR_W-1:0] dest = '0;
    logic [DATA_W-1:0] op_a = '0;
    logic [DATA_W-1:0] op_b = '0;
    logic              busy, done, dbz, we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    muldiv_seq_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .dest(dest),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .dbz(dbz),
        .wa(wa), .wd(wd), .we(we)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] reg_model [16];

    typedef struct {
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              done;
        int                cyc;
    } exp_t;
    exp_t sb[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT presents is matched against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got wa=%0h wd=%0h, expected no write", wa, wd);
            end else begin
                e = sb.pop_front();
                checkOutput("wb_addr", wa, e.wa);
                checkOutput("wb_data", wd, e.wd);
                checkOutput("wb_done", done, e.done);
                checkOutput("wb_cycle", cyc, e.cyc);
            end
            reg_model[wa] = wd;
        end else if (!rst && done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_without_we: got done=1, expected 0");
        end
    end

    task automatic applyStimulus(input logic t_op, input logic [ADDR_W-1:0] t_dest,
                                 input logic [DATA_W-1:0] t_a, input logic [DATA_W-1:0] t_b,
                                 output int n);
        @(negedge clk);
        start = 1'b1;
        op    = t_op;
        dest  = t_dest;
        op_a  = t_a;
        op_b  = t_b;
        @(posedge clk);
        #1;
        n     = cyc;
        start = 1'b0;
        op    = ~t_op;
        dest  = ~t_dest;
        op_a  = ~t_a;
        op_b  = ~t_b;
    endtask

    task automatic pushExpect(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] lo,
                              input logic [DATA_W-1:0] hi, input int n, input bit early);
        exp_t e;
        int base;
        base   = early ? 0 : DATA_W;
        e.wa   = d;
        e.wd   = lo;
        e.done = 1'b0;
        e.cyc  = n + base;
        sb.push_back(e);
        e.wa   = d + ADDR_W'(1);
        e.wd   = hi;
        e.done = 1'b1;
        e.cyc  = n + base + 1;
        sb.push_back(e);
    endtask

    task automatic waitIdle(input int n, input bit early, input string name);
        bit seen;
        int lat;
        seen = 1'b0;
        lat  = early ? 2 : DATA_W + 2;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got busy stuck high, expected idle within 40 cycles", name);
        end else begin
            checkOutput(name, cyc, n + lat);
        end
    endtask

    task automatic runOp(input string name, input logic t_op, input logic [ADDR_W-1:0] t_dest,
                         input logic [DATA_W-1:0] t_a, input logic [DATA_W-1:0] t_b,
                         input logic [DATA_W-1:0] lo, input logic [DATA_W-1:0] hi,
                         input logic exp_dbz, input bit early);
        int n;
        logic [ADDR_W-1:0] d1;
        d1 = t_dest + ADDR_W'(1);
        $display("[TB] %s", name);
        applyStimulus(t_op, t_dest, t_a, t_b, n);
        pushExpect(t_dest, lo, hi, n, early);
        checkOutput("busy_after_accept", busy, 1);
        checkOutput("dbz_at_accept", dbz, exp_dbz);
        waitIdle(n, early, "busy_fall_cycle");
        checkOutput("reg_lo", reg_model[t_dest], lo);
        checkOutput("reg_hi", reg_model[d1], hi);
        checkOutput("dbz_sticky", dbz, exp_dbz);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) reg_model[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_dbz", dbz, 0);
        checkOutput("reset_we", we, 0);
        checkOutput("reset_wa", wa, 0);
        checkOutput("reset_wd", wd, 0);
        @(negedge clk);
        rst = 1'b0;

        runOp("MUL 0x0F*0x11 dest 2", 1'b0, 4'd2, 8'h0F, 8'h11, 8'hFF, 8'h00, 1'b0, 1'b0);
        runOp("MUL 0xFF*0xFF dest 15", 1'b0, 4'd15, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
        runOp("DIV 200/7 dest 4", 1'b1, 4'd4, 8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, 1'b0);
        runOp("DIV 0x37/0 dest 8", 1'b1, 4'd8, 8'h37, 8'h00, 8'hFF, 8'h37, 1'b1, EO);
        runOp("MUL 2*3 dest 8", 1'b0, 4'd8, 8'd2, 8'd3, 8'h06, 8'h00, 1'b0, 1'b0);

        // Starts during CALC and during WB_HI must both be ignored.
        $display("[TB] MUL 0x12*0x05 dest 6 with ignored starts");
        applyStimulus(1'b0, 4'd6, 8'h12, 8'h05, n);
        pushExpect(4'd6, 8'h5A, 8'h00, n, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 1'b1; dest = 4'd10; op_a = 8'h40; op_b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        checkOutput("dbz_after_ignored_start", dbz, 0);
        while (cyc < n + DATA_W + 1) @(negedge clk);
        start = 1'b1; op = 1'b1; dest = 4'd10; op_a = 8'h40; op_b = 8'h02;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_wbhi_start", busy, 0);
        checkOutput("idle_cycle_after_wbhi", cyc, n + DATA_W + 2);
        @(posedge clk);
        #1;
        checkOutput("still_idle", busy, 0);
        checkOutput("reg6", reg_model[6], 8'h5A);
        checkOutput("reg7", reg_model[7], 8'h00);
        checkOutput("reg10_untouched", reg_model[10], 8'h00);

        // Reset in the middle of a MUL: no writes may follow.
        $display("[TB] MUL 0x5A*0x03 dest 12 aborted by reset");
        applyStimulus(1'b0, 4'd12, 8'h5A, 8'h03, n);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_we", we, 0);
        checkOutput("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("abort_reg12", reg_model[12], 8'h00);
        checkOutput("abort_reg13", reg_model[13], 8'h00);
        checkOutput("abort_busy_later", busy, 0);

        runOp("MUL 0x5A*0 dest 1", 1'b0, 4'd1, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, EO);

        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
